// File: rtl/lab_pkg.sv
// Shared constants and helpers for the shift/load datapath.
package lab_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = 4;

  // Smallest counter width whose all-ones value can still represent WIDTH.
  function automatic int min_cnt_w(input int width);
    int w;
    w = 1;
    while (((1 << w) - 1) < width) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_shift_n.sv
// WIDTH-bit register: async active-low clear, parallel load (priority),
// right shift with serial input, serial output taken from bit 0.
module reg_shift_n
  import lab_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_shift_en,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_q,
  output logic             o_serial_out
);

  logic [WIDTH-1:0] r_q;

  // Load wins over shift; otherwise the register holds.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_shift_en) begin
      r_q <= {i_serial_in, r_q[WIDTH-1:1]};
    end
  end

  assign o_q          = r_q;
  assign o_serial_out = r_q[0];

endmodule

// File: rtl/shift_register_unit.sv
// Two chained shift registers (A feeds B) plus a saturating shift counter,
// a pass-complete flag and a sticky over-shift flag.
module shift_register_unit
  import lab_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Din,
  input  logic             Ld_A,
  input  logic             Ld_B,
  input  logic             Shift_En,
  input  logic             Shift_In,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Shift_Out,
  output logic [CNT_W-1:0] Shift_Cnt,
  output logic             Done,
  output logic             Over
);

  // The counter must be able to reach WIDTH, otherwise Done never fires.
  if (CNT_W < min_cnt_w(WIDTH)) begin : g_cnt_w_check
    $error("shift_register_unit: CNT_W too small for WIDTH");
  end

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             w_a_serial_out;
  logic             w_any_load;
  logic             w_done;
  logic [CNT_W-1:0] r_shift_cnt;
  logic             r_over;

  reg_shift_n #(.WIDTH(WIDTH)) u_reg_a (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .i_load       (Ld_A),
    .i_din        (Din),
    .i_shift_en   (Shift_En),
    .i_serial_in  (Shift_In),
    .o_q          (A),
    .o_serial_out (w_a_serial_out)
  );

  // B takes the bit A held before the edge, so the pair acts as one chain
  // even when A is being loaded on the same edge.
  reg_shift_n #(.WIDTH(WIDTH)) u_reg_b (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .i_load       (Ld_B),
    .i_din        (Din),
    .i_shift_en   (Shift_En),
    .i_serial_in  (w_a_serial_out),
    .o_q          (B),
    .o_serial_out (Shift_Out)
  );

  assign w_any_load = Ld_A | Ld_B;
  assign w_done     = (r_shift_cnt == CNT_DONE);

  // Shift counter: any load clears it, shifts count up and saturate.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_shift_cnt <= '0;
    end else if (w_any_load) begin
      r_shift_cnt <= '0;
    end else if (Shift_En && (r_shift_cnt != CNT_MAX)) begin
      r_shift_cnt <= r_shift_cnt + 1'b1;
    end
  end

  // Over flag: sticky once a shift happens past a complete pass.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_over <= 1'b0;
    end else if (w_any_load) begin
      r_over <= 1'b0;
    end else if (Shift_En && w_done) begin
      r_over <= 1'b1;
    end
  end

  assign Shift_Cnt = r_shift_cnt;
  assign Done      = w_done;
  assign Over      = r_over;

endmodule

// File: tb/tb_shift_register_unit.sv
// Self-checking bench: directed cases with literal expectations plus a long
// random run compared every cycle against a 16-bit chain model.
module tb_shift_register_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             Clk;
  logic             Reset_n;
  logic [WIDTH-1:0] Din;
  logic             Ld_A;
  logic             Ld_B;
  logic             Shift_En;
  logic             Shift_In;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Shift_Out;
  logic [CNT_W-1:0] Shift_Cnt;
  logic             Done;
  logic             Over;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 0;

  // Reference model state
  logic [15:0] m_chain;   // {A, B}
  int          m_cnt;
  bit          m_over;

  shift_register_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Din       (Din),
    .Ld_A      (Ld_A),
    .Ld_B      (Ld_B),
    .Shift_En  (Shift_En),
    .Shift_In  (Shift_In),
    .A         (A),
    .B         (B),
    .Shift_Out (Shift_Out),
    .Shift_Cnt (Shift_Cnt),
    .Done      (Done),
    .Over      (Over)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the whole A:B pair is one 16-bit right shift, then any load
  // overwrites its half; counter and flag follow the textual rules.
  always @(posedge Clk or negedge Reset_n) begin
    logic [15:0] shifted;
    logic [7:0]  na, nb;
    if (!Reset_n) begin
      m_chain = 16'h0;
      m_cnt   = 0;
      m_over  = 0;
    end else begin
      shifted = Shift_En ? {Shift_In, m_chain[15:1]} : m_chain;
      na = Ld_A ? Din : shifted[15:8];
      nb = Ld_B ? Din : shifted[7:0];
      if (Ld_A || Ld_B) begin
        m_cnt  = 0;
        m_over = 0;
      end else if (Shift_En) begin
        if (m_cnt == 8) m_over = 1;
        m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
      end
      m_chain = {na, nb};
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (check_en) begin
      check("mdl_A",    32'(A),         32'(m_chain[15:8]));
      check("mdl_B",    32'(B),         32'(m_chain[7:0]));
      check("mdl_cnt",  32'(Shift_Cnt), 32'(m_cnt));
      check("mdl_done", 32'(Done),      32'(m_cnt == 8));
      check("mdl_over", 32'(Over),      32'(m_over));
      check("mdl_sout", 32'(Shift_Out), 32'(m_chain[0]));
    end
  end

  // One clock of stimulus; leaves the bench 2 time units after the edge.
  task automatic drive(input bit la, input bit lb, input bit se, input bit si, input logic [7:0] d);
    Ld_A = la; Ld_B = lb; Shift_En = se; Shift_In = si; Din = d;
    @(posedge Clk);
    #2;
    $display("txn la=%0b lb=%0b se=%0b si=%0b din=%02h -> A=%02h B=%02h cnt=%0d done=%0b over=%0b",
             la, lb, se, si, d, A, B, Shift_Cnt, Done, Over);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0;
    Din = '0; Ld_A = 0; Ld_B = 0; Shift_En = 0; Shift_In = 0;
    repeat (2) @(posedge Clk);
    #2;
    check("rst_A", 32'(A), 32'h0);
    check("rst_B", 32'(B), 32'h0);
    check("rst_cnt", 32'(Shift_Cnt), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    check("rst_over", 32'(Over), 32'h0);
    check("rst_sout", 32'(Shift_Out), 32'h0);
    Reset_n = 1'b1;
    check_en = 1;

    // Build non-zero state, then reset asynchronously mid-cycle.
    drive(1, 0, 0, 0, 8'hFF);
    check("pre_rst_A", 32'(A), 32'hFF);
    repeat (9) drive(0, 0, 1, 1, 8'h00);
    check("pre_rst_B", 32'(B), 32'hFF);
    check("pre_rst_cnt", 32'(Shift_Cnt), 32'd9);
    check("pre_rst_over", 32'(Over), 32'h1);
    Shift_En = 0;
    #1;
    Reset_n = 1'b0;
    #1;
    check("async_A", 32'(A), 32'h0);
    check("async_B", 32'(B), 32'h0);
    check("async_cnt", 32'(Shift_Cnt), 32'h0);
    check("async_over", 32'(Over), 32'h0);
    @(posedge Clk);
    #2;
    Reset_n = 1'b1;

    // Load and full pass
    drive(1, 0, 0, 0, 8'hC5);
    drive(0, 1, 0, 0, 8'h3A);
    repeat (8) drive(0, 0, 1, 0, 8'h00);
    check("pass_A", 32'(A), 32'h00);
    check("pass_B", 32'(B), 32'hC5);
    check("pass_cnt", 32'(Shift_Cnt), 32'd8);
    check("pass_done", 32'(Done), 32'h1);
    check("pass_over", 32'(Over), 32'h0);

    // Over-shift and saturation
    drive(0, 0, 1, 1, 8'h00);
    check("over_A", 32'(A), 32'h80);
    check("over_B", 32'(B), 32'h62);
    check("over_flag", 32'(Over), 32'h1);
    check("over_cnt", 32'(Shift_Cnt), 32'd9);
    check("over_done", 32'(Done), 32'h0);
    repeat (10) drive(0, 0, 1, 0, 8'h00);
    check("sat_cnt", 32'(Shift_Cnt), 32'd15);
    check("sat_over", 32'(Over), 32'h1);

    // Load/shift collision
    drive(1, 0, 0, 0, 8'h01);
    drive(0, 1, 0, 0, 8'h00);
    check("col_over_clr", 32'(Over), 32'h0);
    drive(1, 0, 1, 0, 8'hAA);
    check("col_A", 32'(A), 32'hAA);
    check("col_B", 32'(B), 32'h80);
    check("col_cnt", 32'(Shift_Cnt), 32'd0);

    // Both loads together, then hold
    drive(1, 1, 0, 0, 8'h5A);
    check("both_A", 32'(A), 32'h5A);
    check("both_B", 32'(B), 32'h5A);
    drive(0, 1, 0, 0, 8'hA5);
    repeat (5) drive(0, 0, 0, 0, 8'h00);
    check("hold_A", 32'(A), 32'h5A);
    check("hold_B", 32'(B), 32'hA5);
    check("hold_sout", 32'(Shift_Out), 32'h1);
    check("hold_cnt", 32'(Shift_Cnt), 32'd0);

    // Random sequence
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
    end

    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_register_unit.md
Name: shift_register_unit

Overview:
- Datapath stage directly downstream of the shift/load control FSM. It consumes Ld_A, Ld_B and Shift_En.
- Holds two WIDTH-bit registers, A and B, that are parallel-loaded from switch data and shifted right as one 2*WIDTH chain. A[0] feeds B[MSB].
- Tracks the number of shifts since the last load and flags completion of a full WIDTH-bit pass, for display logic and the bench.

Parameters:
- WIDTH, 8, bit width of each of A and B.
- CNT_W, 4, width of the shift counter; must satisfy 2^CNT_W - 1 >= WIDTH.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- Din  in  WIDTH  parallel load data.
- Ld_A  in  1  load A from Din.
- Ld_B  in  1  load B from Din.
- Shift_En  in  1  shift the A:B chain right one bit.
- Shift_In  in  1  serial bit entering A[MSB] on a shift.
- A  out  WIDTH  contents of register A.
- B  out  WIDTH  contents of register B.
- Shift_Out  out  1  equals B[0], the bit that leaves on the next shift.
- Shift_Cnt  out  CNT_W  shifts since the last load, saturating.
- Done  out  1  high when Shift_Cnt == WIDTH.
- Over  out  1  sticky flag: a shift occurred while Done was high.

Behaviour:
- Reset: Reset_n low asynchronously clears all of the following to 0: A, B, Shift_Cnt, Over. Done is therefore 0 and Shift_Out is 0.
- Reset mid-shift sequence clears everything immediately. There is no partial-state recovery.
- All updates are registered with 1-cycle latency. Outputs reflect the values after the capturing edge.
- Per-register priority is load over shift. Each register is decided independently:
  - A: if Ld_A then A <= Din; else if Shift_En then A <= {Shift_In, A[WIDTH-1:1]}; else hold.
  - B: if Ld_B then B <= Din; else if Shift_En then B <= {A_old[0], B[WIDTH-1:1]}, where A_old is A before the edge; else hold.
- Simultaneous Ld_A and Shift_En: A loads Din, and B still shifts in the old A[0].
- Simultaneous Ld_B and Shift_En: B loads Din, and A still shifts.
- Ld_A and Ld_B together: both load the same Din.
- Shift counter:
  - Cleared to 0 on any edge where Ld_A or Ld_B is high. Clearing takes precedence over incrementing.
  - Otherwise, increments by 1 on each Shift_En edge.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Done is combinational from Shift_Cnt: (Shift_Cnt == WIDTH).
- Over:
  - Set on a Shift_En edge (with no load) when Shift_Cnt == WIDTH beforehand.
  - Cleared only by a load or by reset. It stays set through further shifts.
- Shift_Out = B[0], combinational.
- No internal FSM beyond the counter and flags. The block must be correct for any input sequence, not only sequences the control FSM generates.

Decomposition:
- Shared package (lab_pkg) holds:
  - WIDTH_DEFAULT = 8 and CNT_W_DEFAULT = 4.
  - A helper function that computes the minimum CNT_W for a given WIDTH, used by an elaboration-time assertion.
- One sub-module is natural: reg_shift_n. It is a WIDTH-bit register with async active-low clear, a parallel load that takes priority, a right shift with a serial input, and a serial output of bit 0.
- shift_register_unit instantiates reg_shift_n twice, chains A.serial_out to B.serial_in, and adds the counter and flags.

Test Plan:
- Reset: drive Reset_n low asynchronously mid-cycle after loading A=8'hFF -> A, B, Shift_Cnt and Over read 0 before the next Clk edge.
- Load and full pass: Din=8'hC5 with Ld_A, then Din=8'h3A with Ld_B, then 8 cycles of Shift_En with Shift_In=0 -> A=8'h00, B=8'hC5, Shift_Cnt=8, Done=1, Over=0.
- Over-shift: continue from the previous case with 1 more Shift_En, Shift_In=1 -> A=8'h80, B=8'h62, Over=1, Shift_Cnt=9. Then 10 more shifts -> Shift_Cnt saturates at 15.
- Load/shift collision: A=8'h01, B=8'h00; one edge with Ld_A=1, Din=8'hAA, Shift_En=1 -> A=8'hAA, B=8'h80, Shift_Cnt=0.
- Hold: all controls low for 5 cycles after A=8'h5A, B=8'hA5 -> values unchanged, Shift_Out=1, and the counter is unchanged.
- Random sequence: 2000 cycles of random Ld_A, Ld_B, Shift_En, Shift_In and Din checked against a 16-bit reference model -> A, B, Shift_Cnt, Done and Over match on every cycle.
